sobel_conv_kernel: RTL and testbench
====================================

Name: sobel_conv_kernel

Overview:
Streaming SIZE x SIZE 2-D convolution engine for a raster-scan luminance stream, used for Sobel edge detection in the paddle-localization pipeline. It sits between the YUV converter (Y channel) and the frame dumper/VGA output. It keeps SIZE-1 line buffers plus a sliding window, multiplies the window by a run-time signed kernel and outputs the absolute value of the sum, saturated to the pixel range.

Parameters:
SIZE, 3, window edge length (odd, >=3).
LINE_WIDTH, 640, pixels per image line (line-buffer depth).
PIXEL_DEPTH, 8, unsigned input/output pixel width.
KERNEL_WIDTH, 4, signed two's-complement coefficient width.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
valid_i  input  1  inputLUM holds a valid pixel this cycle.
inputLUM  input  PIXEL_DEPTH  unsigned luminance pixel, raster order.
kernel  input  SIZE*SIZE*KERNEL_WIDTH  signed coefficients; coefficient k[i][j] at bits [(j*SIZE+i)*KERNEL_WIDTH +: KERNEL_WIDTH], i = column (0 = leftmost/oldest), j = row (0 = top/oldest line).
valid_o  output  1  outputEdge valid this cycle.
outputEdge  output  PIXEL_DEPTH  saturated |convolution|.

Behaviour:
- One clock domain; reset synchronous, active-high, and the clock and reset ports are named clk and reset.
- Reset: valid_o=0, outputEdge=0, accepted-pixel counter=0. Line-buffer and window contents need not be cleared; they are don't-care until re-primed.
- Accept: a pixel is accepted on each rising edge with valid_i=1 and reset=0. When valid_i=0, there is no shift, no counter change and state is held, so gaps are allowed anywhere.
- Window: after accepting pixel p, tap w[j][i] holds the pixel accepted (SIZE-1-j)*LINE_WIDTH + (SIZE-1-i) accepts earlier. w[SIZE-1][SIZE-1] = p.
- Sum: S = sum over i,j of signed(k[i][j]) * unsigned(w[j][i]), in full precision of at least PIXEL_DEPTH+KERNEL_WIDTH+ceil(log2(SIZE*SIZE))+1 bits signed. No intermediate overflow is permitted.
- Output value: |S|; if |S| > 2^PIXEL_DEPTH-1, output 2^PIXEL_DEPTH-1.
- Priming: counter counts accepts and saturates at PRIME = (SIZE-1)*LINE_WIDTH + (SIZE-1). An accept is qualifying once the count including this accept is >= PRIME+1; for SIZE=3 the first qualifying accept is the (2*LINE_WIDTH+3)th. Non-qualifying accepts produce no output.
- Latency: for a qualifying accept at edge t, the registered outputs update at edge t+1. valid_o=1 for exactly that cycle. The result is computed from the window including the pixel accepted at t.
- At edge t+1, valid_o=0 unless edge t was itself a qualifying accept, so back-to-back accepts give back-to-back outputs. outputEdge holds its last value while valid_o=0.
- No border handling: windows straddling line or frame wrap are computed as-is. Outputs per frame = accepts - PRIME (first frame); after that, continuous.
- Kernel is sampled combinationally each output calculation; changing it mid-stream affects the next output only.
- Reset mid-stream: at the next edge valid_o=0 and the counter clears; full re-priming is required. Reset dominates valid_i in the same cycle, and that pixel is not accepted.

Test Plan:
LINE_WIDTH=8, SIZE=3, kernel rows (j=0..2) = [-1 0 1],[-2 0 2],[-1 0 1]. PRIME=18.
1. Priming: reset, then continuous valid_i with constant pixel 100 -> valid_o first high the cycle after the 19th accept, then every cycle; outputEdge=0.
2. Step edge: columns 0-3 = 0, columns 4-7 = 10 -> window with left column 0 and middle/right columns 10 gives S=40, outputEdge=40. Same step with 200 -> S=800, outputEdge=255 (saturation).
3. Negative gradient: columns 0-3 = 50, columns 4-7 = 0 -> S=-200, outputEdge=200 (absolute value).
4. Gapped input: repeat case 2 with valid_i toggling 1,0,1,0 -> identical output sequence; valid_o only the cycle after each qualifying accept.
5. Kernel all ones, uniform pixel 20 -> outputEdge=180. Kernel all -8, pixel 255 -> outputEdge=255.
6. Reset after 30 accepts -> valid_o=0 next cycle; the next output appears only the cycle after the 19th post-reset accept.

Source files
------------

// File: rtl/sobel_conv_kernel_if.sv
// Pixel stream bundle for the Sobel convolution engine.
// The master side drives pixels and the kernel; the slave side returns edge pixels.
interface sobel_conv_kernel_if #(
  parameter int SIZE         = 3,
  parameter int PIXEL_DEPTH  = 8,
  parameter int KERNEL_WIDTH = 4
);
  logic                                valid_i;
  logic [PIXEL_DEPTH-1:0]              inputLUM;
  logic [SIZE*SIZE*KERNEL_WIDTH-1:0]   kernel;
  logic                                valid_o;
  logic [PIXEL_DEPTH-1:0]              outputEdge;

  modport master (
    output valid_i, inputLUM, kernel,
    input  valid_o, outputEdge
  );

  modport slave (
    input  valid_i, inputLUM, kernel,
    output valid_o, outputEdge
  );
endinterface

// File: rtl/sobel_conv_kernel.sv
// Streaming SIZE x SIZE convolution over a raster luminance stream: line buffers
// feed a sliding window, and the output is the saturated |sum| of window * kernel.
module sobel_conv_kernel #(
  parameter int SIZE         = 3,
  parameter int LINE_WIDTH   = 640,
  parameter int PIXEL_DEPTH  = 8,
  parameter int KERNEL_WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  sobel_conv_kernel_if.slave bus
);

  localparam int PRIME  = (SIZE-1)*LINE_WIDTH + (SIZE-1);
  localparam int CNT_W  = $clog2(PRIME+1);
  localparam int ADDR_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int TAPS   = SIZE*SIZE;
  localparam int SUM_W  = PIXEL_DEPTH + KERNEL_WIDTH + $clog2(TAPS) + 1;
  localparam logic [SUM_W-1:0] PIX_MAX = {{(SUM_W-PIXEL_DEPTH){1'b0}}, {PIXEL_DEPTH{1'b1}}};

  logic                   accept;
  logic                   qualify;
  logic [CNT_W-1:0]       cnt_reg;
  logic [ADDR_W-1:0]      ptr_reg;
  logic [ADDR_W-1:0]      ptr_next;
  logic [ADDR_W-1:0]      rd_addr;
  logic [PIXEL_DEPTH-1:0] row_in [SIZE];
  logic [PIXEL_DEPTH-1:0] win_reg [SIZE][SIZE];
  logic signed [SUM_W-1:0] prod [TAPS];
  logic signed [SUM_W-1:0] sum;
  logic [SUM_W-1:0]       mag;
  logic [PIXEL_DEPTH-1:0] sat;
  logic                   qual_reg;
  logic                   valid_out_reg;
  logic [PIXEL_DEPTH-1:0] edge_out_reg;

  assign accept  = bus.valid_i;
  assign qualify = accept && (cnt_reg == CNT_W'(PRIME));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      ptr_reg <= '0;
    end else if (accept) begin
      if (cnt_reg != CNT_W'(PRIME)) cnt_reg <= cnt_reg + 1'b1;
      ptr_reg <= ptr_next;
    end
  end

  // Read address runs one slot ahead on an accept so the registered read
  // already holds the line-delayed pixel when the next accept arrives.
  assign ptr_next = (ptr_reg == ADDR_W'(LINE_WIDTH-1)) ? '0 : ptr_reg + 1'b1;
  assign rd_addr  = reset ? '0 : (accept ? ptr_next : ptr_reg);

  assign row_in[SIZE-1] = bus.inputLUM;

  genvar gi;
  generate
    for (gi = 0; gi < SIZE-1; gi++) begin : g_line
      logic [PIXEL_DEPTH-1:0] mem [LINE_WIDTH];
      logic [PIXEL_DEPTH-1:0] rd_data_reg;

      always_ff @(posedge clk) begin
        if (!reset && accept) mem[ptr_reg] <= row_in[gi+1];
        rd_data_reg <= mem[rd_addr];
      end

      assign row_in[gi] = rd_data_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      for (int j = 0; j < SIZE; j++) begin
        for (int i = 0; i < SIZE-1; i++) win_reg[j][i] <= win_reg[j][i+1];
        win_reg[j][SIZE-1] <= row_in[j];
      end
    end
  end

  // Tap t covers column t % SIZE of row t / SIZE, matching the kernel packing.
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      logic [KERNEL_WIDTH-1:0] coef;
      logic signed [SUM_W-1:0] coef_ext;
      logic signed [SUM_W-1:0] pix_ext;

      assign coef     = bus.kernel[gi*KERNEL_WIDTH +: KERNEL_WIDTH];
      assign coef_ext = {{(SUM_W-KERNEL_WIDTH){coef[KERNEL_WIDTH-1]}}, coef};
      assign pix_ext  = {{(SUM_W-PIXEL_DEPTH){1'b0}}, win_reg[gi/SIZE][gi%SIZE]};
      assign prod[gi] = coef_ext * pix_ext;
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int t = 0; t < TAPS; t++) sum = sum + prod[t];
    mag = sum[SUM_W-1] ? -sum : sum;
    sat = (mag > PIX_MAX) ? {PIXEL_DEPTH{1'b1}} : mag[PIXEL_DEPTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qual_reg      <= 1'b0;
      valid_out_reg <= 1'b0;
      edge_out_reg  <= '0;
    end else begin
      qual_reg      <= qualify;
      valid_out_reg <= qual_reg;
      if (qual_reg) edge_out_reg <= sat;
    end
  end

  assign bus.valid_o    = valid_out_reg;
  assign bus.outputEdge = edge_out_reg;

endmodule

// File: tb/tb_sobel_conv_kernel.sv
// Directed bench for sobel_conv_kernel with LINE_WIDTH=8, SIZE=3 (18 accepts to prime).
// Expected outputs are hand-derived per stimulus pattern and checked every cycle.
module tb_sobel_conv_kernel;

  localparam int SIZE = 3;
  localparam int LW   = 8;
  localparam int PD   = 8;
  localparam int KW   = 4;
  localparam int PRIME = (SIZE-1)*LW + (SIZE-1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_conv_kernel_if #(.SIZE(SIZE), .PIXEL_DEPTH(PD), .KERNEL_WIDTH(KW)) bus ();

  sobel_conv_kernel #(
    .SIZE(SIZE), .LINE_WIDTH(LW), .PIXEL_DEPTH(PD), .KERNEL_WIDTH(KW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_compared   = 0;
  int   n_mismatched = 0;
  logic pend_valid   = 1'b0;
  int   pend_edge    = 0;
  int   hold_edge    = 0;
  int   kc [9];

  task automatic check_val(input string tag, input logic [31:0] observed, input int expected);
    n_compared++;
    if (observed !== 32'(expected)) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [SIZE*SIZE*KW-1:0] pack_kernel(input int c [9]);
    logic [SIZE*SIZE*KW-1:0] k;
    k = '0;
    for (int t = 0; t < 9; t++) k[t*KW +: KW] = KW'(c[t]);
    return k;
  endfunction

  // Pattern depends only on column, so all three window rows match and a
  // Sobel-x response is 4*(P[c] - P[c-2]): nonzero only at columns 0,1,4,5.
  function automatic int step_pix(input int c, input int left, input int right);
    return (c < 4) ? left : right;
  endfunction

  function automatic int step_exp(input int c, input int amp);
    int v;
    v = (4*amp > 255) ? 255 : 4*amp;
    return (c == 0 || c == 1 || c == 4 || c == 5) ? v : 0;
  endfunction

  // Drive one cycle, then check the output produced by the previous cycle.
  task automatic cyc(input string tag, input logic v, input logic [7:0] p,
                     input logic ev, input int ee);
    bus.valid_i  = v;
    bus.inputLUM = p;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "/valid_o"}, 32'(bus.valid_o), int'(pend_valid));
    if (pend_valid) hold_edge = pend_edge;
    check_val({tag, "/outputEdge"}, 32'(bus.outputEdge), hold_edge);
    if (bus.valid_o)
      $display("%s: valid_o=1 outputEdge=%0d", tag, bus.outputEdge);
    pend_valid = ev;
    pend_edge  = ee;
  endtask

  task automatic do_reset(input string tag, input logic v);
    reset        = 1'b1;
    bus.valid_i  = v;
    bus.inputLUM = 8'd77;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "/rst_valid_o"}, 32'(bus.valid_o), 0);
    check_val({tag, "/rst_outputEdge"}, 32'(bus.outputEdge), 0);
    $display("%s: reset valid_o=%0d outputEdge=%0d", tag, bus.valid_o, bus.outputEdge);
    reset       = 1'b0;
    bus.valid_i = 1'b0;
    pend_valid  = 1'b0;
    hold_edge   = 0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.valid_i  = 1'b0;
    bus.inputLUM = '0;
    kc = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    bus.kernel = pack_kernel(kc);
    repeat (2) @(negedge clk);

    // 1: priming with constant 100 -> zero gradient, first output after accept 19
    do_reset("prime", 1'b0);
    for (int n = 0; n < 30; n++) cyc("prime", 1'b1, 8'd100, n >= PRIME, 0);
    cyc("prime", 1'b0, 8'd0, 1'b0, 0);

    // 2: rising step amplitude 10, then 200 (saturates)
    do_reset("step10", 1'b0);
    for (int n = 0; n < 32; n++)
      cyc("step10", 1'b1, 8'(step_pix(n % LW, 0, 10)), n >= PRIME, step_exp(n % LW, 10));
    cyc("step10", 1'b0, 8'd0, 1'b0, 0);

    do_reset("step200", 1'b0);
    for (int n = 0; n < 32; n++)
      cyc("step200", 1'b1, 8'(step_pix(n % LW, 0, 200)), n >= PRIME, step_exp(n % LW, 200));
    cyc("step200", 1'b0, 8'd0, 1'b0, 0);

    // 3: falling step, absolute value
    do_reset("neg50", 1'b0);
    for (int n = 0; n < 32; n++)
      cyc("neg50", 1'b1, 8'(step_pix(n % LW, 50, 0)), n >= PRIME, step_exp(n % LW, 50));
    cyc("neg50", 1'b0, 8'd0, 1'b0, 0);

    // 4: gapped version of step 10
    do_reset("gap", 1'b0);
    for (int n = 0; n < 32; n++) begin
      cyc("gap", 1'b1, 8'(step_pix(n % LW, 0, 10)), n >= PRIME, step_exp(n % LW, 10));
      cyc("gap", 1'b0, 8'd99, 1'b0, 0);
    end

    // 5: all-ones kernel, then all -8 kernel
    kc = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    bus.kernel = pack_kernel(kc);
    do_reset("ones", 1'b0);
    for (int n = 0; n < 24; n++) cyc("ones", 1'b1, 8'd20, n >= PRIME, 180);
    cyc("ones", 1'b0, 8'd0, 1'b0, 0);

    kc = '{-8, -8, -8, -8, -8, -8, -8, -8, -8};
    bus.kernel = pack_kernel(kc);
    do_reset("neg8", 1'b0);
    for (int n = 0; n < 24; n++) cyc("neg8", 1'b1, 8'd255, n >= PRIME, 255);
    cyc("neg8", 1'b0, 8'd0, 1'b0, 0);

    // 7: only k[0][0]=1 with ramp pixel n -> output is the pixel 18 accepts back
    kc = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    bus.kernel = pack_kernel(kc);
    do_reset("tap00", 1'b0);
    for (int n = 0; n < 30; n++) cyc("tap00", 1'b1, 8'(n), n >= PRIME, n - PRIME);

    // 6: reset after 30 accepts while valid_i=1; pixel 77 must not be accepted
    do_reset("midrst", 1'b1);
    for (int n = 0; n < 25; n++)
      cyc("midrst", 1'b1, 8'(100 + n), n >= PRIME, 100 + n - PRIME);
    cyc("midrst", 1'b0, 8'd0, 1'b0, 0);

    // 8: only k[i=2][j=1] = -2 -> output |-2 * pixel 8 accepts back|
    kc = '{0, 0, 0, 0, 0, -2, 0, 0, 0};
    bus.kernel = pack_kernel(kc);
    do_reset("tap21", 1'b0);
    for (int n = 0; n < 30; n++) cyc("tap21", 1'b1, 8'(n), n >= PRIME, 2 * (n - 8));
    cyc("tap21", 1'b0, 8'd0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
